// File: rtl/predictor_scheduler.sv
// Arbitrates between fetch lookups and execute resolutions for a branch
// predictor, tracking in-flight predictions in a small circular queue.
module predictor_scheduler #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fetch_req,
  output logic                     fetch_grant,
  input  logic                     exec_valid,
  input  logic                     exec_taken,
  output logic                     exec_ack,
  output logic                     pred_request,
  output logic                     pred_result,
  output logic                     pred_taken,
  input  logic                     pred_prediction,
  output logic                     pred_valid,
  output logic                     pred_out,
  output logic                     mispredict,
  output logic [$clog2(DEPTH):0]   inflight,
  output logic                     underflow_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WAIT_PRED, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [DEPTH-1:0] fifo_q, fifo_d;
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             misp_q, misp_d;
  logic             uflow_q, uflow_d;

  // State, queue and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fifo_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      misp_q  <= 1'b0;
      uflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fifo_q  <= fifo_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      misp_q  <= misp_d;
      uflow_q <= uflow_d;
    end
  end

  // Next-state and handshake decode; resolution wins over lookup in IDLE.
  always_comb begin
    state_d      = state_q;
    fifo_d       = fifo_q;
    head_d       = head_q;
    tail_d       = tail_q;
    cnt_d        = cnt_q;
    misp_d       = 1'b0;
    uflow_d      = uflow_q;
    fetch_grant  = 1'b0;
    exec_ack     = 1'b0;
    pred_request = 1'b0;
    pred_result  = 1'b0;
    pred_taken   = 1'b0;
    pred_valid   = 1'b0;
    pred_out     = 1'b0;

    case (state_q)
      IDLE: begin
        if (exec_valid) begin
          exec_ack = 1'b1;
          if (cnt_q != '0) begin
            pred_result = 1'b1;
            pred_taken  = exec_taken;
            if (fifo_q[head_q] != exec_taken) begin
              head_d  = '0;
              tail_d  = '0;
              cnt_d   = '0;
              misp_d  = 1'b1;
              state_d = FLUSH;
            end else begin
              head_d = head_q + PW'(1);
              cnt_d  = cnt_q - CW'(1);
            end
          end else begin
            uflow_d = 1'b1;
          end
        end else if (fetch_req && (cnt_q < CW'(DEPTH))) begin
          fetch_grant  = 1'b1;
          pred_request = 1'b1;
          state_d      = WAIT_PRED;
        end
      end
      WAIT_PRED: begin
        pred_valid     = 1'b1;
        pred_out       = pred_prediction;
        fifo_d[tail_q] = pred_prediction;
        tail_d         = tail_q + PW'(1);
        cnt_d          = cnt_q + CW'(1);
        state_d        = IDLE;
      end
      FLUSH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Combinational outputs are held quiet while reset is asserted.
    if (!rst_n) begin
      fetch_grant  = 1'b0;
      exec_ack     = 1'b0;
      pred_request = 1'b0;
      pred_result  = 1'b0;
      pred_taken   = 1'b0;
      pred_valid   = 1'b0;
      pred_out     = 1'b0;
    end
  end

  assign mispredict    = misp_q;
  assign inflight      = cnt_q;
  assign underflow_err = uflow_q;

endmodule
